// File: rtl/mdio_master.sv
// Clause 22 MDIO station-management initiator: takes one command at a time, frames it
// onto MDC/MDIO and returns a single-cycle response with read data and TA error.
module mdio_master #(
    parameter int MDC_DIV = 40,
    parameter int PRE_LEN = 32
) (
    input  logic        clk_200m,
    input  logic        rst_200m,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_phy_addr,
    input  logic [4:0]  cmd_reg_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oen
);

    localparam int SLOT_LEN = 2 * MDC_DIV;
    localparam int CYC_W    = $clog2(SLOT_LEN);
    localparam logic [CYC_W-1:0] CYC_LAST   = CYC_W'(SLOT_LEN - 1);
    localparam logic [CYC_W-1:0] CYC_MDC_HI = CYC_W'(MDC_DIV);
    localparam logic [4:0] PRE_LAST  = 5'(PRE_LEN - 1);
    localparam logic [4:0] HDR_LAST  = 5'd13;
    localparam logic [4:0] TA_LAST   = 5'd1;
    localparam logic [4:0] DATA_LAST = 5'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_HDR,
        ST_TA,
        ST_DATA,
        ST_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [4:0]        bit_q, bit_d;
    logic              write_q, write_d;
    logic [4:0]        phy_q, phy_d;
    logic [4:0]        reg_q, reg_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [15:0]       shift_q, shift_d;
    logic              err_q, err_d;
    logic [1:0]        sync_q;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [15:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              mdc_q, mdc_d;
    logic              mdio_out_q, mdio_out_d;
    logic              mdio_oen_q, mdio_oen_d;

    logic              mdio_in_s;
    logic              slot_end;
    logic [13:0]       hdr_d;
    logic [3:0]        tx_idx;

    assign mdio_in_s = sync_q[1];
    assign slot_end  = (cyc_q == CYC_LAST);

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves one unassigned (no latch).
        state_d     = state_q;
        cyc_d       = cyc_q;
        bit_d       = bit_q;
        write_d     = write_q;
        phy_d       = phy_q;
        reg_d       = reg_q;
        wdata_d     = wdata_q;
        shift_d     = shift_q;
        err_d       = err_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        if (state_q == ST_IDLE) begin
            if (cmd_valid && cmd_ready_q) begin
                write_d = cmd_write;
                phy_d   = cmd_phy_addr;
                reg_d   = cmd_reg_addr;
                wdata_d = cmd_wdata;
                err_d   = 1'b0;
                cyc_d   = '0;
                bit_d   = '0;
                state_d = (PRE_LEN == 0) ? ST_HDR : ST_PRE;
            end
        end else begin
            cyc_d = slot_end ? '0 : cyc_q + 1'b1;
            if (slot_end) begin
                bit_d = bit_q + 1'b1;
                case (state_q)
                    ST_PRE: begin
                        if (bit_q == PRE_LAST) begin
                            state_d = ST_HDR;
                            bit_d   = '0;
                        end
                    end
                    ST_HDR: begin
                        if (bit_q == HDR_LAST) begin
                            state_d = ST_TA;
                            bit_d   = '0;
                        end
                    end
                    ST_TA: begin
                        // A responder that never pulls the line low in TA2 leaves a 1 here.
                        if (!write_q && bit_q == TA_LAST) err_d = mdio_in_s;
                        if (bit_q == TA_LAST) begin
                            state_d = ST_DATA;
                            bit_d   = '0;
                        end
                    end
                    ST_DATA: begin
                        if (!write_q) shift_d = {shift_q[14:0], mdio_in_s};
                        if (bit_q == DATA_LAST) begin
                            state_d = ST_GAP;
                            bit_d   = '0;
                        end
                    end
                    ST_GAP: begin
                        state_d     = ST_IDLE;
                        bit_d       = '0;
                        rsp_valid_d = 1'b1;
                        if (!write_q) rsp_rdata_d = shift_q;
                        rsp_err_d   = !write_q && err_q;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end

        // Pad outputs are decoded from next state so the registers change exactly at slot start.
        hdr_d      = {2'b01, (write_d ? 2'b01 : 2'b10), phy_d, reg_d};
        tx_idx     = '0;
        mdio_out_d = 1'b1;
        mdio_oen_d = 1'b1;
        mdc_d      = (state_d != ST_IDLE) && (cyc_d >= CYC_MDC_HI);
        case (state_d)
            ST_PRE: mdio_oen_d = 1'b0;
            ST_HDR: begin
                tx_idx     = 4'(HDR_LAST - bit_d);
                mdio_out_d = hdr_d[tx_idx];
                mdio_oen_d = 1'b0;
            end
            ST_TA: begin
                if (write_d) begin
                    mdio_out_d = (bit_d == 5'd0);
                    mdio_oen_d = 1'b0;
                end
            end
            ST_DATA: begin
                if (write_d) begin
                    tx_idx     = 4'(DATA_LAST - bit_d);
                    mdio_out_d = wdata_d[tx_idx];
                    mdio_oen_d = 1'b0;
                end
            end
            default: ;
        endcase

        // Ready stays low during the response cycle, so a new accept lands one cycle after it.
        cmd_ready_d = (state_d == ST_IDLE) && !rsp_valid_d;
    end

    always_ff @(posedge clk_200m) begin
        if (rst_200m) begin
            state_q     <= ST_IDLE;
            cyc_q       <= '0;
            bit_q       <= '0;
            write_q     <= 1'b0;
            phy_q       <= '0;
            reg_q       <= '0;
            wdata_q     <= '0;
            shift_q     <= '0;
            err_q       <= 1'b0;
            sync_q      <= 2'b11;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mdc_q       <= 1'b0;
            mdio_out_q  <= 1'b1;
            mdio_oen_q  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            bit_q       <= bit_d;
            write_q     <= write_d;
            phy_q       <= phy_d;
            reg_q       <= reg_d;
            wdata_q     <= wdata_d;
            shift_q     <= shift_d;
            err_q       <= err_d;
            sync_q      <= {sync_q[0], mdio_in};
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mdc_q       <= mdc_d;
            mdio_out_q  <= mdio_out_d;
            mdio_oen_q  <= mdio_oen_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mdc       = mdc_q;
    assign mdio_out  = mdio_out_q;
    assign mdio_oen  = mdio_oen_q;

endmodule
